// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: runs a WIDTH-bit add/subtract over a SLICE-bit full-adder
// chain, one slice per clock, with a registered carry between slices.
//
// Optional feature macro: ADDSUB_SEQ_OVF_EN
//   defined   -> overflow = carry into MSB XOR carry out of MSB
//   undefined -> overflow tied to 0, MSB carry-in capture removed
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready decoded from state, IDLE only)
//   op_a, op_b, sub     operands and operation (0 = a+b, 1 = a-b), sampled on accept
//   out_valid/out_ready result handshake
//   result              WIDTH-bit sum/difference
//   carry_out           carry out of MSB (for sub, 1 = no borrow)
//   overflow            signed two's-complement overflow
module addsub_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               accept_c;
    logic               run_c;
    logic               last_c;
    logic               release_c;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;

    logic [SLICE-1:0]   a_s;
    logic [SLICE-1:0]   b_s;
    logic [SLICE-1:0]   slice_sum;
    logic [SLICE:0]     chain_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        run_c     = 1'b0;
        last_c    = 1'b0;
        release_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                run_c = 1'b1;
                if (idx_q == IDX_W'(N - 1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    release_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = (state_q == IDLE);

    // Ripple chain of one-bit full adders over the current slice
    always_comb begin
        a_s        = a_q[idx_q*SLICE +: SLICE];
        b_s        = b_q[idx_q*SLICE +: SLICE];
        slice_sum  = '0;
        chain_c    = '0;
        chain_c[0] = carry_q;
        for (int i = 0; i < int'(SLICE); i++) begin
            slice_sum[i]  = a_s[i] ^ b_s[i] ^ chain_c[i];
            chain_c[i+1]  = (a_s[i] & b_s[i]) | (chain_c[i] & (a_s[i] ^ b_s[i]));
        end
    end

    // Operand capture, slice accumulation and result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q     <= op_a;
                // Two's-complement subtract: invert b, initial carry = 1
                b_q     <= sub ? ~op_b : op_b;
                carry_q <= sub;
                idx_q   <= '0;
            end
            if (run_c) begin
                result[idx_q*SLICE +: SLICE] <= slice_sum;
                carry_q <= chain_c[SLICE];
                idx_q   <= idx_q + IDX_W'(1);
                if (last_c) begin
                    carry_out <= chain_c[SLICE];
`ifdef ADDSUB_SEQ_OVF_EN
                    overflow  <= chain_c[SLICE-1] ^ chain_c[SLICE];
`else
                    overflow  <= 1'b0;
`endif
                    out_valid <= 1'b1;
                end
            end
            if (release_c) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
module tb_addsub_seq_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SLICE = 8;
    localparam int unsigned N     = WIDTH / SLICE;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    addsub_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: wide arithmetic plus sign-rule overflow
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        exp_t       e;
        logic [WIDTH:0] full;
        logic [WIDTH-1:0] bb;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(s);
        e.r  = full[WIDTH-1:0];
        e.c  = full[WIDTH];
`ifdef ADDSUB_SEQ_OVF_EN
        if (!s) e.v = (a[WIDTH-1] == b[WIDTH-1]) && (e.r[WIDTH-1] != a[WIDTH-1]);
        else    e.v = (a[WIDTH-1] != b[WIDTH-1]) && (e.r[WIDTH-1] != a[WIDTH-1]);
`else
        e.v = 1'b0;
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and hold it until accepted; pushes expectation on accept
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        int n;
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        sub  = s;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("issue_timeout", 64'(n >= 50), 64'(0));
        tick();
        sb.push_back(model(a, b, s));
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        sub  = 1'($urandom);
    endtask

    // Wait for out_valid, check latency and result fields; returns the expectation
    task automatic wait_result(input string tag, output exp_t e);
        int cyc;
        cyc = 0;
        e   = '0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(N));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(1), 64'(0));
        end else begin
            e = sb.pop_front();
            check({tag, "_result"},    64'(result),    64'(e.r));
            check({tag, "_carry_out"}, 64'(carry_out), 64'(e.c));
            check({tag, "_overflow"},  64'(overflow),  64'(e.v));
        end
    endtask

    // Complete the output handshake; DONE->IDLE takes exactly one edge
    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_low"},   64'(out_valid), 64'(0));
        check({tag, "_in_ready"}, 64'(in_ready),  64'(1));
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        exp_t e;
        issue(a, b, s);
        wait_result(tag, e);
        release_result(tag);
    endtask

    initial begin
        exp_t e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result",    64'(result),    64'(0));
        check("rst_carry_out", 64'(carry_out), 64'(0));
        check("rst_overflow",  64'(overflow),  64'(0));

        run_op("wrap_add",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("borrow",    32'h0000_0005, 32'h0000_0007, 1'b1);
        run_op("ovf_add",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("ovf_sub",   32'h8000_0000, 32'h0000_0001, 1'b1);
        run_op("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1);
        run_op("carry_mid", 32'h00FF_00FF, 32'h0001_0001, 1'b0);

        // Backpressure with a pending second request
        issue(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_result("bp", e);
        in_valid = 1'b1;
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h0BAD_F00D;
        sub  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_in_ready",  64'(in_ready),  64'(0));
            check("bp_result",    64'(result),    64'(e.r));
            check("bp_carry_out", 64'(carry_out), 64'(e.c));
            check("bp_overflow",  64'(overflow),  64'(e.v));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ov_low",   64'(out_valid), 64'(0));
        check("bp_in_ready", 64'(in_ready),  64'(1));
        issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        wait_result("bp2", e);
        release_result("bp2");

        // Reset during the 2nd RUN cycle discards the operation
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        void'(sb.pop_back());
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready",  64'(in_ready),  64'(1));
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < int'(N) + 3; i++) begin
            tick();
            check("mid_rst_no_valid", 64'(out_valid), 64'(0));
        end
        run_op("post_rst", 32'h0000_1234, 32'h0000_4321, 1'b0);

        // Random operations
        for (int i = 0; i < 8; i++) begin
            run_op("rand", $urandom, $urandom, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
